// File: rtl/fdct_mul_pkg.sv
// Shared types and helpers for the FDCT constant-coefficient multiplier.
// Imported by the multiplier pipeline and its round/saturate stage.
package fdct_mul_pkg;

   localparam int   MAX_STAGE    = 6;
   localparam logic SAT_POS_SIGN = 1'b0;
   localparam logic SAT_NEG_SIGN = 1'b1;

   typedef logic [MAX_STAGE-1:0] stage_vld_t;

   function automatic int full_w(input int a, input int b);
      return a + b;
   endfunction

endpackage

// File: rtl/fdct_mul_round_sat.sv
// Rounding arithmetic right shift followed by signed saturation.
// Maps an exact product onto the narrower output word.
module fdct_mul_round_sat
   import fdct_mul_pkg::*;
#(
   parameter int SHIFT     = 0,
   parameter int ROUND     = 0,
   parameter int IN_W      = 30,
   parameter int OUT_WIDTH = 29
) (
   input  logic signed [IN_W-1:0]      prod_i,
   output logic signed [OUT_WIDTH-1:0] dout_o,
   output logic                        sat_o
);

   // One guard bit so the rounding add can never wrap.
   localparam int EXT_W = IN_W + 1;
   localparam int RSH   = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [EXT_W-1:0] ONE = 1;
   localparam logic signed [EXT_W-1:0] RND =
      (ROUND != 0 && SHIFT > 0) ? (ONE <<< RSH) : '0;

   logic signed [EXT_W-1:0] sum;
   logic signed [EXT_W-1:0] shr;

   assign sum = $signed({prod_i[IN_W-1], prod_i}) + RND;
   assign shr = sum >>> SHIFT;

   generate
      if (OUT_WIDTH >= EXT_W) begin : g_wide
         assign dout_o = OUT_WIDTH'(shr);
         assign sat_o  = 1'b0;
      end else begin : g_sat
         localparam logic [OUT_WIDTH-1:0] SAT_MAX =
            {SAT_POS_SIGN, {(OUT_WIDTH-1){~SAT_POS_SIGN}}};
         localparam logic [OUT_WIDTH-1:0] SAT_MIN =
            {SAT_NEG_SIGN, {(OUT_WIDTH-1){~SAT_NEG_SIGN}}};

         logic [EXT_W-OUT_WIDTH:0] hi;
         logic                     fits;

         // Fits when every bit above the output sign equals it.
         assign hi   = shr[EXT_W-1:OUT_WIDTH-1];
         assign fits = (&hi) | (~|hi);

         always_comb begin
            sat_o  = ~fits;
            dout_o = shr[OUT_WIDTH-1:0];
            if (!fits) begin
               dout_o = shr[EXT_W-1] ? SAT_MIN : SAT_MAX;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/fdct_mul_pipe.sv
// Elastic pipelined signed x unsigned multiplier for the FDCT datapath.
// Valid/ready flow control with a single global advance enable.
module fdct_mul_pipe
   import fdct_mul_pkg::*;
#(
   parameter int DIN0_WIDTH = 16,
   parameter int DIN1_WIDTH = 14,
   parameter int NUM_STAGE  = 3,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0,
   parameter int OUT_WIDTH  = 29
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DIN0_WIDTH-1:0] din0,
   input  logic        [DIN1_WIDTH-1:0] din1,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [OUT_WIDTH-1:0]  dout,
   output logic                         dout_sat
);

   localparam int FW = full_w(DIN0_WIDTH, DIN1_WIDTH);
   localparam stage_vld_t STAGE_MASK = stage_vld_t'((1 << NUM_STAGE) - 1);
   localparam stage_vld_t LAST_BIT   = stage_vld_t'(1 << (NUM_STAGE - 1));

   function automatic logic signed [FW-1:0] mul(
      input logic signed [DIN0_WIDTH-1:0] a,
      input logic        [DIN1_WIDTH-1:0] b
   );
      logic signed [FW-1:0] ax;
      logic signed [FW-1:0] bx;
      ax = FW'(a);
      bx = $signed(FW'(b));
      return ax * bx;
   endfunction

   logic                        rdy_q;
   logic                        adv;
   logic                        acc;
   logic                        last_ld;
   stage_vld_t                  vld_q;
   stage_vld_t                  vld_d;
   logic signed [FW-1:0]        prod;
   logic signed [OUT_WIDTH-1:0] rs_dout;
   logic                        rs_sat;
   logic signed [OUT_WIDTH-1:0] dout_q;
   logic                        sat_q;

   assign out_valid = |(vld_q & LAST_BIT);
   assign adv       = !out_valid || out_ready;
   assign in_ready  = rdy_q && adv;
   assign acc       = in_valid && in_ready;
   assign vld_d     = adv ? ({vld_q[MAX_STAGE-2:0], acc} & STAGE_MASK)
                          : vld_q;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rdy_q <= 1'b0;
         vld_q <= '0;
      end else begin
         rdy_q <= 1'b1;
         vld_q <= vld_d;
      end
   end

   generate
      if (NUM_STAGE == 1) begin : g_s1
         assign prod    = mul(din0, din1);
         assign last_ld = acc;
      end else begin : g_sn
         logic signed [DIN0_WIDTH-1:0] a_q;
         logic        [DIN1_WIDTH-1:0] b_q;

         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (acc) begin
               a_q <= din0;
               b_q <= din1;
            end
         end

         assign last_ld = adv && vld_q[NUM_STAGE-2];

         if (NUM_STAGE == 2) begin : g_s2
            assign prod = mul(a_q, b_q);
         end else begin : g_s3
            logic signed [FW-1:0] p_q [2:NUM_STAGE-1];

            // Data only moves with a valid item, so idle inputs never leak in.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
               if (!ap_rst_n) begin
                  for (int s = 2; s <= NUM_STAGE - 1; s++) begin
                     p_q[s] <= '0;
                  end
               end else begin
                  if (adv && vld_q[0]) begin
                     p_q[2] <= mul(a_q, b_q);
                  end
                  for (int s = 3; s <= NUM_STAGE - 1; s++) begin
                     if (adv && vld_q[s-2]) begin
                        p_q[s] <= p_q[s-1];
                     end
                  end
               end
            end

            assign prod = p_q[NUM_STAGE-1];
         end
      end
   endgenerate

   fdct_mul_round_sat #(
      .SHIFT    (SHIFT),
      .ROUND    (ROUND),
      .IN_W     (FW),
      .OUT_WIDTH(OUT_WIDTH)
   ) u_rs (
      .prod_i(prod),
      .dout_o(rs_dout),
      .sat_o (rs_sat)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         dout_q <= '0;
         sat_q  <= 1'b0;
      end else if (last_ld) begin
         dout_q <= rs_dout;
         sat_q  <= rs_sat;
      end
   end

   assign dout     = dout_q;
   assign dout_sat = sat_q;

endmodule
